// File: rtl/multiplicador_secuencial_if.sv
// multiplicador_secuencial_if: start/operand/result bundle of the sequential signed multiplier
//   start    request, sampled only while the multiplier is idle
//   A, B     N-bit two's-complement operands, sampled with start
//   Producto 2N-bit signed product, held between operations
//   busy     operation in progress
//   done     one-cycle pulse when Producto shows a new result
interface multiplicador_secuencial_if #(parameter int N = 25);
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] Producto;
    logic           busy;
    logic           done;
    modport master (output start, A, B, input Producto, busy, done);
    modport slave  (input start, A, B, output Producto, busy, done);
endinterface

// File: rtl/multiplicador_secuencial.sv
// multiplicador_secuencial: radix-2 shift-add signed multiplier, N+1 cycles from start to result
//   clk    rising-edge clock
//   reset  synchronous active-high reset, aborts any operation without a done pulse
//   bus    slave side of multiplicador_secuencial_if (start, A, B in; Producto, busy, done out)
module multiplicador_secuencial #(parameter int N = 25) (
    input logic                       clk,
    input logic                       reset,
    multiplicador_secuencial_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t         state;
    logic           sign;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] partial;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    // Magnitudes as N-bit unsigned: negating -2^(N-1) wraps to 2^(N-1), which is the correct magnitude
    assign mag_a = bus.A[N-1] ? -bus.A : bus.A;
    assign mag_b = bus.B[N-1] ? -bus.B : bus.B;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.Producto <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            sign         <= 1'b0;
            mcand        <= '0;
            mplier       <= '0;
            partial      <= '0;
            cnt          <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sign     <= bus.A[N-1] ^ bus.B[N-1];
                    mcand    <= {{N{1'b0}}, mag_a};
                    mplier   <= mag_b;
                    partial  <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= CALC;
                end
                CALC: begin
                    partial <= mplier[0] ? partial + mcand : partial;
                    mplier  <= mplier >> 1;
                    mcand   <= mcand << 1;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= FIN;
                end
                FIN: begin
                    // -0 == 0, so a zero product needs no special handling
                    bus.Producto <= sign ? -partial : partial;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// tb_multiplicador_secuencial: directed checks of the sequential signed multiplier (N=25)
module tb_multiplicador_secuencial;
    localparam int N = 25;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int passed = 0;
    int lat;
    int bc;
    int dn;
    multiplicador_secuencial_if #(.N(N)) bus ();
    multiplicador_secuencial #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic go(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A = N'($urandom);
        bus.B = N'($urandom);
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (bus.done !== 1'b1 && l < 200) begin
            tick();
            l++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        tick();
        tick();
        check("rst_producto", 64'(bus.Producto), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        tick();
        // 3*5: latency and busy width
        go(25'd3, 25'd5);
        bc = bus.busy ? 1 : 0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
            if (bus.busy) bc++;
        end
        check("lat_3x5", 64'(lat), 64'd26);
        check("busy_cycles", 64'(bc), 64'd26);
        check("p_3x5", 64'(bus.Producto), 64'd15);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        tick();
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("p_held", 64'(bus.Producto), 64'd15);
        // sign combinations
        go(-25'sd7, 25'sd6);
        wait_done(lat);
        check("p_m7x6", 64'(bus.Producto), 64'h3_FFFF_FFFF_FFD6);
        go(-25'sd7, -25'sd6);
        wait_done(lat);
        check("p_m7xm6", 64'(bus.Producto), 64'h2A);
        // extreme magnitudes
        go(25'h1000000, 25'h1000000);
        wait_done(lat);
        check("p_min_x_min", 64'(bus.Producto), 64'h1_0000_0000_0000);
        go(25'h0FFFFFF, 25'h1000000);
        wait_done(lat);
        check("p_max_x_min", 64'(bus.Producto), 64'h3_0000_0100_0000);
        // zero product, and an unchanged result still pulses done
        go(25'd0, 25'h1FFFFFF);
        wait_done(lat);
        check("done_zero", 64'(bus.done), 64'd1);
        check("p_zero", 64'(bus.Producto), 64'd0);
        tick();
        go(25'd0, 25'h1FFFFFF);
        wait_done(lat);
        check("done_zero_again", 64'(bus.done), 64'd1);
        check("lat_zero_again", 64'(lat), 64'd26);
        check("p_zero_again", 64'(bus.Producto), 64'd0);
        // start while busy is ignored
        go(25'd2, 25'd3);
        repeat (9) tick();
        bus.A = 25'd9;
        bus.B = 25'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(lat);
        check("lat_ignore", 64'(lat), 64'd16);
        check("p_2x3", 64'(bus.Producto), 64'd6);
        // start accepted in the done cycle
        go(25'd4, 25'd4);
        check("busy_after_restart", 64'(bus.busy), 64'd1);
        check("done_after_restart", 64'(bus.done), 64'd0);
        wait_done(lat);
        check("lat_b2b", 64'(lat), 64'd26);
        check("p_4x4", 64'(bus.Producto), 64'd16);
        tick();
        // reset mid-CALC
        go(25'd100, 25'd100);
        repeat (11) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_producto", 64'(bus.Producto), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        dn = 0;
        repeat (40) begin
            tick();
            if (bus.done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        go(25'd2, 25'd2);
        wait_done(lat);
        check("lat_2x2", 64'(lat), 64'd26);
        check("p_2x2", 64'(bus.Producto), 64'd4);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
